// File: rtl/button_debounce_pkg.sv
// Shared board constants for the push-button front end.
package button_debounce_pkg;

  // Default log2 stable-time requirement, in clocks, for board buttons.
  localparam int BUTTON_DEBOUNCE_LGWAIT_DEFAULT = 17;

endpackage : button_debounce_pkg

// File: rtl/button_debounce_chan.sv
// One button channel: 2-FF synchronizer, stable-time counter, debounced
// state bit and (when BUTTON_DEBOUNCE_EVENTS_EN is defined) press/release
// event flops. The *_nxt outputs are the pre-register event terms so the
// top can register a combined event aligned with o_press/o_release.
module button_debounce_chan
  import button_debounce_pkg::*;
#(
  parameter int LGWAIT = BUTTON_DEBOUNCE_LGWAIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in,
  output logic o_debounced
`ifdef BUTTON_DEBOUNCE_EVENTS_EN
  , output logic o_press
  , output logic o_release
  , output logic o_press_nxt
  , output logic o_release_nxt
`endif
);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_deb;
  logic [LGWAIT-1:0] r_cnt;
  logic              w_cnt_max;
  logic              w_flip;

  assign w_cnt_max = &r_cnt;
  // Flip only once the mismatch has persisted through the all-ones count.
  assign w_flip    = (r_sync2 != r_deb) && w_cnt_max;

  // Synchronizer, stable-time counter and debounced state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (!w_cnt_max) begin
        r_cnt <= r_cnt + LGWAIT'(1);
      end else begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end
    end
  end

  assign o_debounced = r_deb;

`ifdef BUTTON_DEBOUNCE_EVENTS_EN
  logic r_press;
  logic r_release;

  assign o_press_nxt   = w_flip &  r_sync2;
  assign o_release_nxt = w_flip & ~r_sync2;

  // Event flops, updated on the same edge as the debounced state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= o_press_nxt;
      r_release <= o_release_nxt;
    end
  end

  assign o_press   = r_press;
  assign o_release = r_release;
`else
  logic w_flip_unused;
  assign w_flip_unused = w_flip;
`endif

endmodule : button_debounce_chan

// File: rtl/button_debounce.sv
// NIN-channel button synchronizer/debouncer with optional press/release
// event pulses. Define BUTTON_DEBOUNCE_EVENTS_EN to build the event
// outputs; otherwise o_press, o_release and o_event are tied to 0.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int NIN    = 8,
  parameter int LGWAIT = BUTTON_DEBOUNCE_LGWAIT_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NIN-1:0] i_in,
  output logic [NIN-1:0] o_debounced,
  output logic [NIN-1:0] o_press,
  output logic [NIN-1:0] o_release,
  output logic           o_event
);

`ifdef BUTTON_DEBOUNCE_EVENTS_EN
  logic [NIN-1:0] w_press_nxt;
  logic [NIN-1:0] w_release_nxt;
  logic           r_event;
`endif

  for (genvar g = 0; g < NIN; g++) begin : g_chan
    button_debounce_chan #(
      .LGWAIT (LGWAIT)
    ) u_chan (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_in          (i_in[g]),
      .o_debounced   (o_debounced[g])
`ifdef BUTTON_DEBOUNCE_EVENTS_EN
      , .o_press       (o_press[g])
      , .o_release     (o_release[g])
      , .o_press_nxt   (w_press_nxt[g])
      , .o_release_nxt (w_release_nxt[g])
`endif
    );
  end

`ifdef BUTTON_DEBOUNCE_EVENTS_EN
  // Combined event, registered from the pre-register terms so it lines up
  // with the per-channel pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_event <= 1'b0;
    end else begin
      r_event <= (|w_press_nxt) | (|w_release_nxt);
    end
  end

  assign o_event = r_event;
`else
  assign o_press   = '0;
  assign o_release = '0;
  assign o_event   = 1'b0;
`endif

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (NIN=8, LGWAIT=2).
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic       i_clk;
  logic       i_reset;
  logic [7:0] i_in;
  logic [7:0] o_debounced;
  logic [7:0] o_press;
  logic [7:0] o_release;
  logic       o_event;

  button_debounce #(
    .NIN    (8),
    .LGWAIT (2)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_in        (i_in),
    .o_debounced (o_debounced),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_event     (o_event)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One scoreboard entry per clock: stimulus to apply, then the outputs
  // expected just after the following rising edge.
  typedef struct {
    logic       rst;
    logic [7:0] in;
    logic [7:0] deb;
    logic [7:0] prs;
    logic [7:0] rel;
    logic       ev;
  } step_t;

  step_t      sb_q[$];
  logic [7:0] model_deb;
  int         total;
  int         bad;

  // Push n quiet cycles: level unchanged, no events.
  task automatic push_hold(input logic rst, input logic [7:0] in, input int n);
    step_t e;
    if (rst) model_deb = 8'h00;
    for (int i = 0; i < n; i++) begin
      e.rst = rst; e.in = in; e.deb = model_deb;
      e.prs = 8'h00; e.rel = 8'h00; e.ev = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  // Push the cycle on which the debounced level changes to new_deb.
  task automatic push_flip(input logic [7:0] in, input logic [7:0] new_deb);
    step_t e;
    e.rst = 1'b0; e.in = in; e.deb = new_deb;
    e.prs = EV ? (new_deb & ~model_deb) : 8'h00;
    e.rel = EV ? (model_deb & ~new_deb) : 8'h00;
    e.ev  = EV ? (new_deb != model_deb) : 1'b0;
    sb_q.push_back(e);
    model_deb = new_deb;
  endtask

  // Drain the scoreboard, one clock per entry, comparing every output.
  task automatic run_sb(input string name);
    step_t e;
    int    k;
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      k++;
      i_reset = e.rst;
      i_in    = e.in;
      @(posedge i_clk);
      #1;
      total++;
      if (o_debounced !== e.deb) begin
        bad++;
        $display("FAIL %s deb step %0d: got %h want %h", name, k, o_debounced, e.deb);
      end
      total++;
      if (o_press !== e.prs) begin
        bad++;
        $display("FAIL %s press step %0d: got %h want %h", name, k, o_press, e.prs);
      end
      total++;
      if (o_release !== e.rel) begin
        bad++;
        $display("FAIL %s release step %0d: got %h want %h", name, k, o_release, e.rel);
      end
      total++;
      if (o_event !== e.ev) begin
        bad++;
        $display("FAIL %s event step %0d: got %b want %b", name, k, o_event, e.ev);
      end
    end
  endtask

  task automatic test_reset();
    push_hold(1'b1, 8'hFF, 4);
    push_hold(1'b0, 8'h00, 8);
    run_sb("reset");
  endtask

  task automatic test_clean_press();
    push_hold(1'b0, 8'h08, 5);
    push_flip(8'h08, 8'h08);
    push_hold(1'b0, 8'h08, 3);
    run_sb("clean_press");
  endtask

  task automatic test_bounce();
    push_hold(1'b0, 8'h09, 1);
    push_hold(1'b0, 8'h08, 1);
    push_hold(1'b0, 8'h09, 5);
    push_flip(8'h09, 8'h09);
    push_hold(1'b0, 8'h09, 3);
    run_sb("bounce");
  endtask

  task automatic test_release();
    push_hold(1'b0, 8'h01, 5);
    push_flip(8'h01, 8'h01);
    push_hold(1'b0, 8'h01, 2);
    push_hold(1'b0, 8'h00, 5);
    push_flip(8'h00, 8'h00);
    push_hold(1'b0, 8'h00, 3);
    run_sb("release");
  endtask

  task automatic test_simultaneous();
    push_hold(1'b0, 8'h04, 5);
    push_flip(8'h04, 8'h04);
    push_hold(1'b0, 8'h04, 2);
    push_hold(1'b0, 8'h02, 5);
    push_flip(8'h02, 8'h02);
    push_hold(1'b0, 8'h02, 3);
    run_sb("simultaneous");
  endtask

  task automatic test_reset_mid_count();
    push_hold(1'b0, 8'h00, 5);
    push_flip(8'h00, 8'h00);
    push_hold(1'b0, 8'h00, 2);
    // press starts at cycle 0, reset asserted at cycle 3, released at cycle 5
    push_hold(1'b0, 8'h01, 3);
    push_hold(1'b1, 8'h01, 2);
    push_hold(1'b0, 8'h01, 5);
    push_flip(8'h01, 8'h01);
    push_hold(1'b0, 8'h01, 3);
    run_sb("reset_mid_count");
  endtask

  task automatic test_back_to_back();
    // Release immediately followed by a re-press on the same channel.
    push_hold(1'b0, 8'h00, 5);
    push_flip(8'h00, 8'h00);
    push_hold(1'b0, 8'h01, 5);
    push_flip(8'h01, 8'h01);
    push_hold(1'b0, 8'h01, 2);
    run_sb("back_to_back");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    model_deb = 8'h00;
    i_reset   = 1'b1;
    i_in      = 8'h00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_debounce
